// File: rtl/piho_lattice_engine_if.sv
// RNG handshake that delivers -ln(u) samples to the lattice engine.
// The source drives data/valid (master); the engine returns ready (slave).
interface piho_lattice_engine_if #(
    parameter int unsigned WIDTH = 32
) ();
    logic [WIDTH-1:0] rng_neglog;
    logic             rng_valid;
    logic             rng_ready;

    modport master (output rng_neglog, output rng_valid, input rng_ready);
    modport slave  (input rng_neglog, input rng_valid, output rng_ready);
endinterface

// File: rtl/piho_lattice_engine.sv
// Path-integral harmonic-oscillator Metropolis engine over a periodic 2^LOG2_SITES lattice.
// Optional x4_sum observable is enabled by defining PIHO_X4SUM_EN.
module piho_lattice_engine #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned FRAC       = 16,
    parameter int unsigned LOG2_SITES = 6,
    parameter int unsigned STEP_BITS  = 10,
    parameter int unsigned ACC_W      = 48
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [15:0]             seed,
    input  logic signed [WIDTH-1:0] init_value,
    input  logic signed [WIDTH-1:0] k1,
    input  logic signed [WIDTH-1:0] k2,
    input  logic [31:0]             total_sweeps,
    input  logic [31:0]             warmup_sweeps,
    piho_lattice_engine_if.slave    rng,
    output logic                    busy,
    output logic                    done,
    output logic [31:0]             sweep_count,
    output logic [31:0]             accept_count,
    output logic [ACC_W-1:0]        x2_sum,
`ifdef PIHO_X4SUM_EN
    output logic [ACC_W-1:0]        x4_sum,
`endif
    output logic signed [WIDTH-1:0] last_x0
);

    localparam int unsigned N  = 2 ** LOG2_SITES;
    localparam int unsigned XW = WIDTH + 1;
    localparam int unsigned DW = 3 * WIDTH + 4;

    typedef enum logic [2:0] {
        StIdle, StInit, StFetch, StMul, StDecide, StWrite, StMeas, StDone
    } state_e;

    state_e                  state_q, state_d;
    logic [LOG2_SITES-1:0]   idx_q, idx_d;
    logic [15:0]             lfsr_q, lfsr_d;
    logic signed [WIDTH-1:0] x_q, x_d;
    logic signed [XW-1:0]    xn_q, xn_d;
    logic signed [WIDTH:0]   nsum_q, nsum_d;
    logic signed [DW-1:0]    ds_q, ds_d;
    logic                    reject_q, reject_d;
    logic                    accept_q, accept_d;
    logic [31:0]             sweep_q, sweep_d;
    logic [31:0]             acc_cnt_q, acc_cnt_d;
    logic [ACC_W-1:0]        x2_q, x2_d;
    logic signed [WIDTH-1:0] x0_q, x0_d;

    logic signed [WIDTH-1:0] sites [N];
    logic                    mem_we;
    logic [LOG2_SITES-1:0]   mem_addr;
    logic signed [WIDTH-1:0] mem_wdata;

    // Position idx_q walks even sites first, then odd sites (checkerboard order).
    logic [LOG2_SITES-1:0]   site, site_m, site_p;
    logic signed [WIDTH-1:0] x_rd, xm_rd, xp_rd, m_rd;
    logic [STEP_BITS-1:0]    inc;
    logic signed [XW-1:0]    xn_calc;
    logic                    lfsr_fb;

    assign site    = {idx_q[LOG2_SITES-2:0], idx_q[LOG2_SITES-1]};
    assign site_m  = site - LOG2_SITES'(1);
    assign site_p  = site + LOG2_SITES'(1);
    assign x_rd    = sites[site];
    assign xm_rd   = sites[site_m];
    assign xp_rd   = sites[site_p];
    assign m_rd    = sites[idx_q];
    assign inc     = lfsr_q[STEP_BITS-1:0];
    assign xn_calc = {x_rd[WIDTH-1], x_rd} + {{(XW-STEP_BITS){inc[STEP_BITS-1]}}, inc};
    assign lfsr_fb = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];

    // Action difference at full precision; every intermediate fits in DW bits.
    logic signed [DW-1:0] xw, xnw, nw, k1w, k2w, ds_full, ds_calc, neg_w;
    logic                 ds_nonpos;

    assign xw        = {{(DW-WIDTH){x_q[WIDTH-1]}}, x_q};
    assign xnw       = {{(DW-XW){xn_q[XW-1]}}, xn_q};
    assign nw        = {{(DW-WIDTH-1){nsum_q[WIDTH]}}, nsum_q};
    assign k1w       = {{(DW-WIDTH){k1[WIDTH-1]}}, k1};
    assign k2w       = {{(DW-WIDTH){k2[WIDTH-1]}}, k2};
    assign ds_full   = k2w * (xnw * xnw - xw * xw) - k1w * (xnw - xw) * nw;
    assign ds_calc   = ds_full >>> FRAC;
    assign neg_w     = {{(DW-WIDTH){rng.rng_neglog[WIDTH-1]}}, rng.rng_neglog};
    assign ds_nonpos = ds_q[DW-1] || (ds_q == '0);

    logic signed [2*WIDTH-1:0] m_ext, m_sq;
    logic [2*WIDTH-1:0]        x2_term;

    assign m_ext   = {{WIDTH{m_rd[WIDTH-1]}}, m_rd};
    assign m_sq    = m_ext * m_ext;
    assign x2_term = m_sq >> FRAC;

`ifdef PIHO_X4SUM_EN
    logic [ACC_W-1:0]   x4_q, x4_d;
    logic [4*WIDTH-1:0] x4_wide, x4_term;

    assign x4_wide = {{(2*WIDTH){1'b0}}, x2_term} * {{(2*WIDTH){1'b0}}, x2_term};
    assign x4_term = x4_wide >> FRAC;
    assign x4_sum  = x4_q;
`endif

    logic [31:0] sweep_inc;
    assign sweep_inc = sweep_q + 32'd1;

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        lfsr_d        = lfsr_q;
        x_d           = x_q;
        xn_d          = xn_q;
        nsum_d        = nsum_q;
        ds_d          = ds_q;
        reject_d      = reject_q;
        accept_d      = accept_q;
        sweep_d       = sweep_q;
        acc_cnt_d     = acc_cnt_q;
        x2_d          = x2_q;
        x0_d          = x0_q;
`ifdef PIHO_X4SUM_EN
        x4_d          = x4_q;
`endif
        mem_we        = 1'b0;
        mem_addr      = site;
        mem_wdata     = xn_q[WIDTH-1:0];
        rng.rng_ready = 1'b0;

        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    lfsr_d    = (seed == 16'h0000) ? 16'h0001 : seed;
                    sweep_d   = '0;
                    acc_cnt_d = '0;
                    x2_d      = '0;
                    x0_d      = '0;
`ifdef PIHO_X4SUM_EN
                    x4_d      = '0;
`endif
                    idx_d     = '0;
                    state_d   = StInit;
                end
            end
            StInit: begin
                mem_we    = 1'b1;
                mem_addr  = idx_q;
                mem_wdata = init_value;
                idx_d     = idx_q + LOG2_SITES'(1);
                if (&idx_q) state_d = (total_sweeps == '0) ? StDone : StFetch;
            end
            StFetch: begin
                x_d     = x_rd;
                xn_d    = xn_calc;
                nsum_d  = {xm_rd[WIDTH-1], xm_rd} + {xp_rd[WIDTH-1], xp_rd};
                lfsr_d  = {lfsr_q[14:0], lfsr_fb};
                state_d = StMul;
            end
            StMul: begin
                ds_d     = ds_calc;
                reject_d = xn_q[XW-1] != xn_q[XW-2];
                state_d  = StDecide;
            end
            StDecide: begin
                if (reject_q) begin
                    accept_d = 1'b0;
                    state_d  = StWrite;
                end else if (ds_nonpos) begin
                    accept_d = 1'b1;
                    state_d  = StWrite;
                end else begin
                    rng.rng_ready = 1'b1;
                    if (rng.rng_valid) begin
                        accept_d = ds_q < neg_w;
                        state_d  = StWrite;
                    end
                end
            end
            StWrite: begin
                if (accept_q) begin
                    mem_we    = 1'b1;
                    acc_cnt_d = acc_cnt_q + 32'd1;
                end
                idx_d   = idx_q + LOG2_SITES'(1);
                state_d = (&idx_q) ? StMeas : StFetch;
            end
            StMeas: begin
                if (sweep_q >= warmup_sweeps) begin
                    x2_d = x2_q + ACC_W'(x2_term);
`ifdef PIHO_X4SUM_EN
                    x4_d = x4_q + ACC_W'(x4_term);
`endif
                end
                if (idx_q == '0) x0_d = m_rd;
                idx_d = idx_q + LOG2_SITES'(1);
                if (&idx_q) begin
                    sweep_d = sweep_inc;
                    state_d = (sweep_inc == total_sweeps) ? StDone : StFetch;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StIdle;
            idx_q     <= '0;
            lfsr_q    <= '0;
            x_q       <= '0;
            xn_q      <= '0;
            nsum_q    <= '0;
            ds_q      <= '0;
            reject_q  <= 1'b0;
            accept_q  <= 1'b0;
            sweep_q   <= '0;
            acc_cnt_q <= '0;
            x2_q      <= '0;
            x0_q      <= '0;
`ifdef PIHO_X4SUM_EN
            x4_q      <= '0;
`endif
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            lfsr_q    <= lfsr_d;
            x_q       <= x_d;
            xn_q      <= xn_d;
            nsum_q    <= nsum_d;
            ds_q      <= ds_d;
            reject_q  <= reject_d;
            accept_q  <= accept_d;
            sweep_q   <= sweep_d;
            acc_cnt_q <= acc_cnt_d;
            x2_q      <= x2_d;
            x0_q      <= x0_d;
`ifdef PIHO_X4SUM_EN
            x4_q      <= x4_d;
`endif
        end
    end

    // Site storage is deliberately unreset; INIT rewrites every entry.
    always_ff @(posedge clk) begin
        if (mem_we) sites[mem_addr] <= mem_wdata;
    end

    assign busy         = (state_q != StIdle) && (state_q != StDone);
    assign done         = state_q == StDone;
    assign sweep_count  = sweep_q;
    assign accept_count = acc_cnt_q;
    assign x2_sum       = x2_q;
    assign last_x0      = x0_q;

endmodule

// File: tb/tb_piho_lattice_engine.sv
// Scoreboard bench for piho_lattice_engine: a reference model pushes expected run results at
// start; they are popped and compared when the engine reports done.
module tb_piho_lattice_engine;

    localparam int N      = 64;
    localparam int BUDGET = 8000;

    logic               clk;
    logic               rst;
    logic               start;
    logic [15:0]        seed;
    logic signed [31:0] init_value, k1, k2;
    logic [31:0]        total_sweeps, warmup_sweeps;
    logic               busy, done;
    logic [31:0]        sweep_count, accept_count;
    logic [47:0]        x2_sum;
    logic [31:0]        last_x0;
`ifdef PIHO_X4SUM_EN
    logic [47:0]        x4_sum;
`endif

    piho_lattice_engine_if #(.WIDTH(32)) rng_bus ();

    piho_lattice_engine dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .seed          (seed),
        .init_value    (init_value),
        .k1            (k1),
        .k2            (k2),
        .total_sweeps  (total_sweeps),
        .warmup_sweeps (warmup_sweeps),
        .rng           (rng_bus),
        .busy          (busy),
        .done          (done),
        .sweep_count   (sweep_count),
        .accept_count  (accept_count),
        .x2_sum        (x2_sum),
`ifdef PIHO_X4SUM_EN
        .x4_sum        (x4_sum),
`endif
        .last_x0       (last_x0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned rng_count = 0;
    always @(posedge clk) if (rng_bus.rng_ready && rng_bus.rng_valid) rng_count <= rng_count + 1;

    typedef struct packed {
        logic [31:0] sweeps;
        logic [31:0] accepts;
        logic [31:0] rng_uses;
        logic [47:0] x2;
        logic [47:0] x4;
        logic [31:0] x0;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_idle_zero(input string tag);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_done"}, 64'(done), 64'd0);
        check({tag, "_ready"}, 64'(rng_bus.rng_ready), 64'd0);
        check({tag, "_sweeps"}, 64'(sweep_count), 64'd0);
        check({tag, "_accepts"}, 64'(accept_count), 64'd0);
        check({tag, "_x2"}, 64'(x2_sum), 64'd0);
        check({tag, "_x0"}, 64'(last_x0), 64'd0);
    endtask

    // Reference model: sequential Metropolis sweep in checkerboard order, 128-bit arithmetic.
    task automatic model_run(input logic [15:0] sd, input logic signed [31:0] init,
                             input logic signed [31:0] k1m, input logic signed [31:0] k2m,
                             input int unsigned total, input int unsigned warm,
                             input logic signed [31:0] nl);
        logic signed [31:0]  m [N];
        logic [15:0]         lf;
        logic signed [9:0]   inc10;
        logic signed [127:0] x, xm, xp, xn, ds, kk1, kk2, nlw, sq, t4;
        int                  site;
        bit                  acc;
        exp_t                e;
        e   = '0;
        lf  = (sd == 16'h0000) ? 16'h0001 : sd;
        kk1 = k1m;
        kk2 = k2m;
        nlw = nl;
        for (int i = 0; i < N; i++) m[i] = init;
        for (int unsigned s = 0; s < total; s++) begin
            for (int o = 0; o < N; o++) begin
                site  = (o < N / 2) ? 2 * o : 2 * (o - N / 2) + 1;
                x     = m[site];
                xm    = m[(site + N - 1) % N];
                xp    = m[(site + 1) % N];
                inc10 = lf[9:0];
                xn    = x + inc10;
                lf    = {lf[14:0], lf[15] ^ lf[13] ^ lf[12] ^ lf[10]};
                if (xn > 128'sd2147483647 || xn < -128'sd2147483648) begin
                    acc = 1'b0;
                end else begin
                    ds = (kk2 * (xn * xn - x * x) - kk1 * (xn - x) * (xm + xp)) >>> 16;
                    if (ds <= 0) begin
                        acc = 1'b1;
                    end else begin
                        e.rng_uses = e.rng_uses + 1;
                        acc        = ds < nlw;
                    end
                end
                if (acc) begin
                    m[site]   = xn[31:0];
                    e.accepts = e.accepts + 1;
                end
            end
            if (s >= warm) begin
                for (int i = 0; i < N; i++) begin
                    x    = m[i];
                    sq   = (x * x) >> 16;
                    t4   = (sq * sq) >> 16;
                    e.x2 = e.x2 + sq[47:0];
                    e.x4 = e.x4 + t4[47:0];
                end
            end
            e.x0     = m[0];
            e.sweeps = e.sweeps + 1;
        end
        sb_q.push_back(e);
    endtask

    task automatic run_case(input string name, input logic [15:0] sd,
                            input logic signed [31:0] init, input logic signed [31:0] k1v,
                            input logic signed [31:0] k2v, input int unsigned total,
                            input int unsigned warm, input logic signed [31:0] nl,
                            input bit do_stall, input bit do_mid_start);
        exp_t        e;
        int          cyc;
        bit          stalled;
        int unsigned rng_base;
        logic [31:0] acc_hold;
        seed                = sd;
        init_value          = init;
        k1                  = k1v;
        k2                  = k2v;
        total_sweeps        = total;
        warmup_sweeps       = warm;
        rng_bus.rng_neglog  = nl;
        rng_bus.rng_valid   = !do_stall;
        model_run(sd, init, k1v, k2v, total, warm, nl);
        @(negedge clk);
        rng_base = rng_count;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({name, "_start_busy"}, 64'(busy), 64'd1);
        check({name, "_start_done"}, 64'(done), 64'd0);
        check({name, "_start_sweeps"}, 64'(sweep_count), 64'd0);
        check({name, "_start_accepts"}, 64'(accept_count), 64'd0);
        check({name, "_start_x2"}, 64'(x2_sum), 64'd0);
        check({name, "_start_x0"}, 64'(last_x0), 64'd0);
        cyc     = 0;
        stalled = 1'b0;
        while (!done && cyc < BUDGET) begin
            @(negedge clk);
            cyc++;
            start = do_mid_start && (cyc == 100);
            seed  = (do_mid_start && cyc == 100) ? ~sd : sd;
            if (do_stall && !stalled && rng_bus.rng_ready && !done) begin
                stalled  = 1'b1;
                acc_hold = accept_count;
                for (int k = 0; k < 20; k++) begin
                    @(negedge clk);
                    check({name, "_stall_ready"}, 64'(rng_bus.rng_ready), 64'd1);
                    check({name, "_stall_busy"}, 64'(busy), 64'd1);
                    check({name, "_stall_frozen"}, 64'(accept_count), 64'(acc_hold));
                end
                rng_bus.rng_valid = 1'b1;
            end
        end
        start = 1'b0;
        check({name, "_done"}, 64'(done), 64'd1);
        check({name, "_busy_end"}, 64'(busy), 64'd0);
        if (total == 0) check({name, "_init_cycles"}, 64'(cyc), 64'(N));
        if (do_stall) check({name, "_stall_seen"}, 64'(stalled), 64'd1);
        e = sb_q.pop_front();
        check({name, "_sweep_count"}, 64'(sweep_count), 64'(e.sweeps));
        check({name, "_accept_count"}, 64'(accept_count), 64'(e.accepts));
        check({name, "_rng_uses"}, 64'(rng_count - rng_base), 64'(e.rng_uses));
        check({name, "_x2_sum"}, 64'(x2_sum), 64'(e.x2));
        check({name, "_last_x0"}, 64'(last_x0), 64'(e.x0));
`ifdef PIHO_X4SUM_EN
        check({name, "_x4_sum"}, 64'(x4_sum), 64'(e.x4));
`endif
    endtask

    initial begin
        rst                = 1'b0;
        start              = 1'b0;
        seed               = '0;
        init_value         = '0;
        k1                 = '0;
        k2                 = '0;
        total_sweeps       = '0;
        warmup_sweeps      = '0;
        rng_bus.rng_neglog = '0;
        rng_bus.rng_valid  = 1'b0;

        #80;
        check_idle_zero("reset");
        @(negedge clk);
        rst = 1'b1;
        repeat (10) @(negedge clk);
        check_idle_zero("post_reset");

        run_case("zero_sweeps", 16'hACE1, 32'sh0, 32'sh0, 32'sh0, 0, 0, 32'sh0, 1'b0, 1'b0);
        run_case("free_walk", 16'h1234, 32'sh0, 32'sh0, 32'sh0, 3, 2, 32'sh0, 1'b0, 1'b0);
        run_case("pinned", 16'hBEEF, 32'sh0, 32'sh0, 32'sh10000, 2, 0, 32'sh0, 1'b0, 1'b0);
        run_case("stall", 16'hBEEF, 32'sh0, 32'sh0, 32'sh10000, 2, 0, 32'sh0, 1'b1, 1'b0);
        run_case("warmup", 16'h0000, 32'sh30000, 32'sh4000, 32'sh8000, 2, 5, 32'sh10000,
                 1'b0, 1'b1);
        run_case("restart", 16'h7A3C, 32'sh30000, 32'sh4000, 32'sh8000, 1, 0, 32'sh10000,
                 1'b0, 1'b0);

        // Mid-run reset must drop every output immediately.
        seed          = 16'h4321;
        init_value    = 32'sh20000;
        k1            = '0;
        k2            = '0;
        total_sweeps  = 32'd4;
        warmup_sweeps = 32'd0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (400) @(negedge clk);
        check("midrun_busy_before_reset", 64'(busy), 64'd1);
        rst = 1'b0;
        #1;
        check_idle_zero("midrun_reset");
        @(negedge clk);
        rst = 1'b1;
        repeat (5) @(negedge clk);
        check_idle_zero("midrun_after_release");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
